// File: rtl/id_ex_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_ex_stage_pipe
//
// Decode-to-execute pipeline slot. Holds one decoded instruction between the
// decode logic and the execute stage, with a valid/ready handshake on both
// sides, a synchronous flush for taken branches, a writeback-to-decode operand
// bypass, and load-use bubble insertion.
//
// Parameters
//   XLEN    : data/operand width (PC, RD1, RD2, Imm)
//   CTRL_W  : width of the opaque control bundle (all-zero means "no effect")
//   RADDR_W : register address width, register 0 is hard-wired zero
//
// Ports
//   clk_i, rst_ni             : rising-edge clock, async active-low reset
//   in_valid_i / in_ready_o   : decode-side handshake
//   in_ctrl_i, in_is_load_i   : decoded control bundle and load marker
//   in_rs1_i/in_rs2_i/in_rd_i : source and destination register addresses
//   in_rd1_i, in_rd2_i        : register-file read data
//   in_imm_i, in_pc_i         : extended immediate and PC
//   wb_we_i/wb_rd_i/wb_data_i : writeback port snooped for bypass/refresh
//   flush_i                   : kill held and incoming instruction
//   out_valid_o / out_ready_i : execute-side handshake
//   out_*_o                   : registered payload
//   load_use_o                : a load-use bubble is inserted this cycle
// -----------------------------------------------------------------------------
module id_ex_stage_pipe #(
    parameter int XLEN    = 32,
    parameter int CTRL_W  = 12,
    parameter int RADDR_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [CTRL_W-1:0]  in_ctrl_i,
    input  logic               in_is_load_i,
    input  logic [RADDR_W-1:0] in_rs1_i,
    input  logic [RADDR_W-1:0] in_rs2_i,
    input  logic [RADDR_W-1:0] in_rd_i,
    input  logic [XLEN-1:0]    in_rd1_i,
    input  logic [XLEN-1:0]    in_rd2_i,
    input  logic [XLEN-1:0]    in_imm_i,
    input  logic [XLEN-1:0]    in_pc_i,
    input  logic               wb_we_i,
    input  logic [RADDR_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]    wb_data_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [CTRL_W-1:0]  out_ctrl_o,
    output logic               out_is_load_o,
    output logic [RADDR_W-1:0] out_rs1_o,
    output logic [RADDR_W-1:0] out_rs2_o,
    output logic [RADDR_W-1:0] out_rd_o,
    output logic [XLEN-1:0]    out_rd1_o,
    output logic [XLEN-1:0]    out_rd2_o,
    output logic [XLEN-1:0]    out_imm_o,
    output logic [XLEN-1:0]    out_pc_o,
    output logic               load_use_o
);

    logic               valid_q,  valid_d;
    logic [CTRL_W-1:0]  ctrl_q,   ctrl_d;
    logic               isLoad_q, isLoad_d;
    logic [RADDR_W-1:0] rs1_q,    rs1_d;
    logic [RADDR_W-1:0] rs2_q,    rs2_d;
    logic [RADDR_W-1:0] rd_q,     rd_d;
    logic [XLEN-1:0]    rd1_q,    rd1_d;
    logic [XLEN-1:0]    rd2_q,    rd2_d;
    logic [XLEN-1:0]    imm_q,    imm_d;
    logic [XLEN-1:0]    pc_q,     pc_d;

    logic advance;
    logic loadUse;
    logic capture;
    logic wbHit;

    // Handshake and hazard detection. The slot can move on when it is empty
    // or execute is taking it; a held load whose destination feeds the
    // incoming instruction forces one bubble. in_ready is gated by reset so
    // that every output reads zero while reset is held.
    always_comb begin
        advance    = !valid_q || out_ready_i;
        loadUse    = in_valid_i && valid_q && isLoad_q && (rd_q != '0) &&
                     ((rd_q == in_rs1_i) || (rd_q == in_rs2_i));
        in_ready_o = rst_ni && advance && !loadUse && !flush_i;
        capture    = in_valid_i && in_ready_o;
        load_use_o = loadUse;
        wbHit      = wb_we_i && (wb_rd_i != '0);
    end

    // Next-state selection. Flush beats everything; a capture loads the new
    // payload with writeback bypass; an advance without capture is a bubble
    // (only control is cleared, data may stay stale); otherwise the slot is
    // stalled and a matching writeback refreshes the held operands so the
    // write is not lost while waiting.
    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        isLoad_d = isLoad_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rd_d     = rd_q;
        rd1_d    = rd1_q;
        rd2_d    = rd2_q;
        imm_d    = imm_q;
        pc_d     = pc_q;

        if (flush_i) begin
            valid_d  = 1'b0;
            ctrl_d   = '0;
            isLoad_d = 1'b0;
        end else if (capture) begin
            valid_d  = 1'b1;
            ctrl_d   = in_ctrl_i;
            isLoad_d = in_is_load_i;
            rs1_d    = in_rs1_i;
            rs2_d    = in_rs2_i;
            rd_d     = in_rd_i;
            rd1_d    = (wbHit && (wb_rd_i == in_rs1_i)) ? wb_data_i : in_rd1_i;
            rd2_d    = (wbHit && (wb_rd_i == in_rs2_i)) ? wb_data_i : in_rd2_i;
            imm_d    = in_imm_i;
            pc_d     = in_pc_i;
        end else if (advance) begin
            valid_d  = 1'b0;
            ctrl_d   = '0;
            isLoad_d = 1'b0;
        end else begin
            if (wbHit && (wb_rd_i == rs1_q)) begin
                rd1_d = wb_data_i;
            end
            if (wbHit && (wb_rd_i == rs2_q)) begin
                rd2_d = wb_data_i;
            end
        end
    end

    // Slot register. Reset drops whatever was held; nothing is replayed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= 1'b0;
            ctrl_q   <= '0;
            isLoad_q <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            isLoad_q <= isLoad_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
        end
    end

    assign out_valid_o   = valid_q;
    assign out_ctrl_o    = ctrl_q;
    assign out_is_load_o = isLoad_q;
    assign out_rs1_o     = rs1_q;
    assign out_rs2_o     = rs2_q;
    assign out_rd_o      = rd_q;
    assign out_rd1_o     = rd1_q;
    assign out_rd2_o     = rd2_q;
    assign out_imm_o     = imm_q;
    assign out_pc_o      = pc_q;

endmodule

// File: tb/tb_id_ex_stage_pipe.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage_pipe
//
// Directed bench for id_ex_stage_pipe with default parameters. Inputs change
// 1 time unit after a rising edge; registered outputs are sampled at that same
// point after the edge, combinational outputs shortly after inputs settle.
// -----------------------------------------------------------------------------
module tb_id_ex_stage_pipe;

    localparam int XLEN    = 32;
    localparam int CTRL_W  = 12;
    localparam int RADDR_W = 5;

    logic               clk;
    logic               rstN;
    logic               inValid;
    logic               inReady;
    logic [CTRL_W-1:0]  inCtrl;
    logic               inIsLoad;
    logic [RADDR_W-1:0] inRs1, inRs2, inRd;
    logic [XLEN-1:0]    inRd1, inRd2, inImm, inPc;
    logic               wbWe;
    logic [RADDR_W-1:0] wbRd;
    logic [XLEN-1:0]    wbData;
    logic               flush;
    logic               outValid;
    logic               outReady;
    logic [CTRL_W-1:0]  outCtrl;
    logic               outIsLoad;
    logic [RADDR_W-1:0] outRs1, outRs2, outRd;
    logic [XLEN-1:0]    outRd1, outRd2, outImm, outPc;
    logic               loadUse;

    int compCount = 0;
    int failCount = 0;

    id_ex_stage_pipe #(
        .XLEN    (XLEN),
        .CTRL_W  (CTRL_W),
        .RADDR_W (RADDR_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .in_valid_i    (inValid),
        .in_ready_o    (inReady),
        .in_ctrl_i     (inCtrl),
        .in_is_load_i  (inIsLoad),
        .in_rs1_i      (inRs1),
        .in_rs2_i      (inRs2),
        .in_rd_i       (inRd),
        .in_rd1_i      (inRd1),
        .in_rd2_i      (inRd2),
        .in_imm_i      (inImm),
        .in_pc_i       (inPc),
        .wb_we_i       (wbWe),
        .wb_rd_i       (wbRd),
        .wb_data_i     (wbData),
        .flush_i       (flush),
        .out_valid_o   (outValid),
        .out_ready_i   (outReady),
        .out_ctrl_o    (outCtrl),
        .out_is_load_o (outIsLoad),
        .out_rs1_o     (outRs1),
        .out_rs2_o     (outRs2),
        .out_rd_o      (outRd),
        .out_rd1_o     (outRd1),
        .out_rd2_o     (outRd2),
        .out_imm_o     (outImm),
        .out_pc_o      (outPc),
        .load_use_o    (loadUse)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the decode-side instruction fields.
    task automatic applyStimulus(input logic v, input logic [CTRL_W-1:0] c,
                                 input logic ld, input logic [RADDR_W-1:0] s1,
                                 input logic [RADDR_W-1:0] s2,
                                 input logic [RADDR_W-1:0] d,
                                 input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                                 input logic [XLEN-1:0] im, input logic [XLEN-1:0] pc);
        inValid  = v;
        inCtrl   = c;
        inIsLoad = ld;
        inRs1    = s1;
        inRs2    = s2;
        inRd     = d;
        inRd1    = r1;
        inRd2    = r2;
        inImm    = im;
        inPc     = pc;
    endtask

    // Drive the writeback snoop port.
    task automatic applyWb(input logic we, input logic [RADDR_W-1:0] rd,
                           input logic [XLEN-1:0] data);
        wbWe   = we;
        wbRd   = rd;
        wbData = data;
    endtask

    // One comparison: counts it, asserts equality, reports on failure.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit past the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN     = 1'b0;
        outReady = 1'b1;
        flush    = 1'b0;
        applyWb(1'b0, '0, '0);
        applyStimulus(1'b1, 12'h3C3, 1'b1, 5'd1, 5'd2, 5'd3,
                      32'hAAAA, 32'hBBBB, 32'hCCCC, 32'hDDDD);

        // Reset held across clock edges: everything stays zero.
        step();
        step();
        checkOutput("rst_valid", outValid, 0);
        checkOutput("rst_ctrl", outCtrl, 0);
        checkOutput("rst_isload", outIsLoad, 0);
        checkOutput("rst_pc", outPc, 0);
        checkOutput("rst_rd1", outRd1, 0);
        checkOutput("rst_rd", outRd, 0);
        checkOutput("rst_loaduse", loadUse, 0);
        checkOutput("rst_inready", inReady, 0);

        rstN = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, '0, '0, '0, '0);
        #1;
        checkOutput("post_rst_inready", inReady, 1);
        checkOutput("post_rst_loaduse", loadUse, 0);

        // Stream of three instructions with execute always ready.
        applyStimulus(1'b1, 12'h123, 1'b0, 5'd1, 5'd2, 5'd3,
                      32'h1000, 32'h2000, 32'h4, 32'h100);
        step();
        checkOutput("s0_valid", outValid, 1);
        checkOutput("s0_ctrl", outCtrl, 12'h123);
        checkOutput("s0_pc", outPc, 32'h100);
        checkOutput("s0_rd1", outRd1, 32'h1000);
        applyStimulus(1'b1, 12'h0A5, 1'b0, 5'd4, 5'd5, 5'd6,
                      32'h3333, 32'h4444, 32'h8, 32'h104);
        step();
        checkOutput("s1_valid", outValid, 1);
        checkOutput("s1_ctrl", outCtrl, 12'h0A5);
        checkOutput("s1_pc", outPc, 32'h104);
        checkOutput("s1_rd", outRd, 6);
        applyStimulus(1'b1, 12'hFFF, 1'b0, 5'd7, 5'd8, 5'd9,
                      32'h5555, 32'hDEADBEEF, 32'hC, 32'h108);
        step();
        checkOutput("s2_valid", outValid, 1);
        checkOutput("s2_ctrl", outCtrl, 12'hFFF);
        checkOutput("s2_rd2", outRd2, 32'hDEADBEEF);
        checkOutput("s2_imm", outImm, 32'hC);
        applyStimulus(1'b0, 12'h111, 1'b0, '0, '0, '0, '0, '0, '0, '0);
        step();
        checkOutput("idle_valid", outValid, 0);
        checkOutput("idle_ctrl", outCtrl, 0);

        // Writeback bypass on capture.
        applyStimulus(1'b1, 12'h010, 1'b0, 5'd5, 5'd6, 5'd1,
                      32'h11, 32'h22, 32'h0, 32'h110);
        applyWb(1'b1, 5'd5, 32'hABCD);
        step();
        checkOutput("byp_rd1", outRd1, 32'hABCD);
        checkOutput("byp_rd2_nohit", outRd2, 32'h22);
        applyStimulus(1'b1, 12'h010, 1'b0, 5'd0, 5'd6, 5'd1,
                      32'h11, 32'h22, 32'h0, 32'h114);
        applyWb(1'b1, 5'd0, 32'hABCD);
        step();
        checkOutput("byp_x0_rd1", outRd1, 32'h11);
        applyStimulus(1'b1, 12'h010, 1'b0, 5'd5, 5'd6, 5'd1,
                      32'h11, 32'h22, 32'h0, 32'h118);
        applyWb(1'b0, 5'd5, 32'hABCD);
        step();
        checkOutput("byp_nowe_rd1", outRd1, 32'h11);
        applyStimulus(1'b1, 12'h010, 1'b0, 5'd4, 5'd9, 5'd1,
                      32'h33, 32'h44, 32'h0, 32'h11C);
        applyWb(1'b1, 5'd9, 32'hBEEF);
        step();
        checkOutput("byp_rd2", outRd2, 32'hBEEF);
        checkOutput("byp_rd1_nohit", outRd1, 32'h33);

        // Stall with hold refresh.
        applyWb(1'b0, '0, '0);
        applyStimulus(1'b1, 12'h321, 1'b0, 5'd6, 5'd7, 5'd8,
                      32'h61, 32'h71, 32'h9, 32'h200);
        step();
        outReady = 1'b0;
        applyStimulus(1'b1, 12'h777, 1'b0, 5'd1, 5'd2, 5'd1,
                      32'h1, 32'h2, 32'h3, 32'h300);
        applyWb(1'b1, 5'd7, 32'h55);
        #1;
        checkOutput("stall_inready", inReady, 0);
        step();
        checkOutput("stall_rd2_refresh", outRd2, 32'h55);
        checkOutput("stall_rd1", outRd1, 32'h61);
        checkOutput("stall_ctrl", outCtrl, 12'h321);
        checkOutput("stall_pc", outPc, 32'h200);
        checkOutput("stall_valid", outValid, 1);
        applyWb(1'b0, 5'd6, 32'h99);
        step();
        checkOutput("stall_rd1_nowe", outRd1, 32'h61);
        checkOutput("stall_rd2_kept", outRd2, 32'h55);
        outReady = 1'b1;
        step();
        checkOutput("unstall_pc", outPc, 32'h300);
        checkOutput("unstall_ctrl", outCtrl, 12'h777);

        // Load-use: one bubble, then the dependent instruction enters.
        applyStimulus(1'b1, 12'h0F0, 1'b1, 5'd1, 5'd2, 5'd3,
                      32'h0, 32'h0, 32'h0, 32'h400);
        step();
        checkOutput("lu_load_isload", outIsLoad, 1);
        applyStimulus(1'b1, 12'h00F, 1'b0, 5'd4, 5'd3, 5'd5,
                      32'h40, 32'h30, 32'h0, 32'h404);
        #1;
        checkOutput("lu_flag", loadUse, 1);
        checkOutput("lu_inready", inReady, 0);
        step();
        checkOutput("lu_bubble_valid", outValid, 0);
        checkOutput("lu_bubble_ctrl", outCtrl, 0);
        checkOutput("lu_bubble_isload", outIsLoad, 0);
        checkOutput("lu_after_flag", loadUse, 0);
        checkOutput("lu_after_inready", inReady, 1);
        step();
        checkOutput("lu_dep_valid", outValid, 1);
        checkOutput("lu_dep_pc", outPc, 32'h404);
        checkOutput("lu_dep_ctrl", outCtrl, 12'h00F);

        // A load to x0 never creates a hazard.
        applyStimulus(1'b1, 12'h011, 1'b1, 5'd1, 5'd2, 5'd0,
                      32'h0, 32'h0, 32'h0, 32'h500);
        step();
        applyStimulus(1'b1, 12'h022, 1'b0, 5'd0, 5'd0, 5'd4,
                      32'h0, 32'h0, 32'h0, 32'h504);
        #1;
        checkOutput("lu_x0_flag", loadUse, 0);
        checkOutput("lu_x0_inready", inReady, 1);

        // Flush overrides back-pressure and blocks capture.
        outReady = 1'b0;
        flush    = 1'b1;
        applyStimulus(1'b1, 12'hABC, 1'b0, 5'd1, 5'd2, 5'd3,
                      32'h0, 32'h0, 32'h0, 32'h600);
        #1;
        checkOutput("fl_inready", inReady, 0);
        step();
        checkOutput("fl_valid", outValid, 0);
        checkOutput("fl_ctrl", outCtrl, 0);
        checkOutput("fl_pc_not_captured", outPc, 32'h500);
        flush = 1'b0;

        // Async reset in the middle of a stall.
        outReady = 1'b1;
        applyStimulus(1'b1, 12'h5A5, 1'b0, 5'd1, 5'd2, 5'd3,
                      32'h77, 32'h0, 32'h0, 32'h700);
        step();
        checkOutput("ar_pre_valid", outValid, 1);
        outReady = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, '0, '0, '0, '0);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("ar_valid", outValid, 0);
        checkOutput("ar_ctrl", outCtrl, 0);
        checkOutput("ar_pc", outPc, 0);
        checkOutput("ar_rd1", outRd1, 0);
        #1;
        rstN = 1'b1;
        step();
        checkOutput("ar_no_replay", outValid, 0);
        outReady = 1'b1;
        applyStimulus(1'b1, 12'h1B2, 1'b0, 5'd1, 5'd2, 5'd3,
                      32'h88, 32'h0, 32'h0, 32'h800);
        step();
        checkOutput("ar_first_valid", outValid, 1);
        checkOutput("ar_first_ctrl", outCtrl, 12'h1B2);
        checkOutput("ar_first_pc", outPc, 32'h800);
        checkOutput("ar_first_rd1", outRd1, 32'h88);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
